axil_ashi_bridge: RTL and testbench
===================================

// Module: axil_ashi_bridge
//
// PURPOSE
//  Protocol core between an AXI4-Lite master and a register-handler block.
//  Terminates the five AXI4-Lite channels and presents each access to the handler
//  as a one-cycle ASHI request (address, register index, data).
//  Waits for the handler to report idle, then returns its response on B or R.
//  Write and read paths are independent FSMs and may run concurrently.
//
// PARAMETERS
//  ADDR_MASK       32'h7F  AND-mask applied to AWADDR/ARADDR before presentation to the handler
//  TIMEOUT_CYCLES  256     Handler-idle wait limit in clocks; used only with AXIL_TIMEOUT_EN
//
// PORTS
//  clk            in   1   clock
//  resetn         in   1   asynchronous active-low reset
//  AXI_AWADDR     in   32  write address
//  AXI_AWVALID    in   1   |  AXI_AWPROT in 3 (ignored)  |  AXI_AWREADY out 1
//  AXI_WDATA      in   32  write data
//  AXI_WSTRB      in   4   ignored; every write is a full word
//  AXI_WVALID     in   1   |  AXI_WREADY out 1
//  AXI_BRESP      out  2   |  AXI_BVALID out 1  |  AXI_BREADY in 1
//  AXI_ARADDR     in   32  |  AXI_ARVALID in 1  |  AXI_ARPROT in 3 (ignored)  |  AXI_ARREADY out 1
//  AXI_RDATA      out  32  |  AXI_RRESP out 2   |  AXI_RVALID out 1  |  AXI_RREADY in 1
//  ASHI_WADDR     out  32  masked write address;  ASHI_WINDX out 32 = ASHI_WADDR >> 2
//  ASHI_WDATA     out  32  write data;  ASHI_WRITE out 1 = one-cycle write strobe
//  ASHI_WRESP     in   2   handler write response;  ASHI_WIDLE in 1 = handler write path idle
//  ASHI_RADDR     out  32  masked read address;  ASHI_RINDX out 32 = ASHI_RADDR >> 2
//  ASHI_READ      out  1   one-cycle read strobe
//  ASHI_RDATA     in   32  |  ASHI_RRESP in 2  |  ASHI_RIDLE in 1 = handler read path idle
//
// BEHAVIOUR
//  Reset (async assert, sync release): every output = 0; both FSMs -> IDLE; held flags cleared.
//  Write FSM states: W_IDLE -> W_EXEC -> W_WAIT -> W_RESP -> W_IDLE.
//   - W_IDLE: AWREADY = !aw_held; WREADY = !w_held. AW and W are captured independently, in any
//     order or in the same cycle; each ready drops the cycle after its handshake.
//   - When both are held: go to W_EXEC and drive ASHI_WADDR/WINDX/WDATA.
//   - W_EXEC: ASHI_WRITE = 1 for exactly one cycle; advance to W_WAIT.
//   - W_WAIT: stay until ASHI_WIDLE = 1; then latch ASHI_WRESP into BRESP, set BVALID, enter W_RESP.
//   - W_RESP: hold BVALID/BRESP stable until BREADY; clear BVALID and held flags; return to W_IDLE.
//  Read FSM: R_IDLE (ARREADY = 1) -> R_EXEC (ASHI_READ one cycle) -> R_WAIT (until ASHI_RIDLE = 1;
//   latch RDATA/RRESP) -> R_RESP (RVALID held stable until RREADY) -> R_IDLE.
//  Minimum latency: handshake at edge N; strobe high in cycle N+1; VALID high at N+3 when the
//   handler reports idle in the first W_WAIT/R_WAIT cycle.
//  Only one outstanding transaction per direction; no new AW, W or AR is accepted until the
//   current response completes.
//  Concurrent read and write: both strobes may assert in the same cycle; no arbitration.
//  ASHI address/data outputs stay stable from the EXEC cycle until the FSM returns to IDLE.
//  Reset mid-transaction: the transaction is dropped silently; no B/R response is issued.
//
// CONFIGURATION
//  AXIL_TIMEOUT_EN defined:
//   - A per-direction counter runs in W_WAIT/R_WAIT.
//   - After TIMEOUT_CYCLES clocks without idle, the response is forced to SLVERR (2'b10) with
//     RDATA = 32'hDEAD_BEEF, and the FSM enters the RESP state.
//  AXIL_TIMEOUT_EN undefined: no counter; the WAIT states wait indefinitely.
//
// TESTING
//  1. AW+W same cycle, addr 0x04, data 0x1234; handler idle next cycle
//     -> ASHI_WINDX = 1, ASHI_WDATA = 0x1234, one-cycle strobe; BVALID at N+3, BRESP = 0.
//  2. W three cycles before AW (addr 0x84)
//     -> single strobe with ASHI_WADDR = 0x04; WREADY low until B completes.
//  3. Read of addr 0x08; handler returns 0xCAFE/OKAY after 5 wait cycles
//     -> RVALID with RDATA = 0xCAFE; stays high through a 4-cycle RREADY stall with data stable.
//  4. Simultaneous AR and AW/W
//     -> both strobes in the same cycle; B and R each complete independently.
//  5. resetn pulsed low while in W_WAIT
//     -> all outputs are 0 immediately; no BVALID afterwards; the next write works normally.
//  6. AXIL_TIMEOUT_EN with TIMEOUT_CYCLES = 16 and RIDLE held low
//     -> RVALID after 16 wait cycles with RRESP = 2, RDATA = 0xDEADBEEF.

Source files
------------

// File: rtl/axil_ashi_bridge.sv
// axil_ashi_bridge
//   Terminates the AXI4-Lite channels and presents each access to a register
//   handler as a one-cycle ASHI strobe with masked address, register index and
//   data. The bridge then waits for the handler to report idle and returns the
//   handler's response on B or R. The write and read paths are independent
//   FSMs and can run concurrently, with one outstanding transaction per direction.
//
// Parameters
//   ADDR_MASK       AND-mask applied to AWADDR/ARADDR before they reach the handler
//   TIMEOUT_CYCLES  handler-idle wait limit in clocks (timeout build only)
//
// Build option
//   AXIL_TIMEOUT_EN  When defined, each WAIT state has a counter. After
//                    TIMEOUT_CYCLES clocks without idle, the FSM returns
//                    SLVERR, and reads also return 32'hDEAD_BEEF.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   AXI_AW*/W*/B*               AXI4-Lite write address, data and response channels
//   AXI_AR*/R*                  AXI4-Lite read address and data channels
//   ASHI_WADDR/WINDX/WDATA      masked write address, word index, write data
//   ASHI_WRITE                  one-cycle write strobe
//   ASHI_WRESP/WIDLE            handler write response, handler write path idle
//   ASHI_RADDR/RINDX            masked read address, word index
//   ASHI_READ                   one-cycle read strobe
//   ASHI_RDATA/RRESP/RIDLE      handler read data, response, read path idle
module axil_ashi_bridge #(
  parameter logic [31:0] ADDR_MASK      = 32'h7F,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] AXI_AWADDR,
  input  logic        AXI_AWVALID,
  input  logic [2:0]  AXI_AWPROT,
  output logic        AXI_AWREADY,
  input  logic [31:0] AXI_WDATA,
  input  logic [3:0]  AXI_WSTRB,
  input  logic        AXI_WVALID,
  output logic        AXI_WREADY,
  output logic [1:0]  AXI_BRESP,
  output logic        AXI_BVALID,
  input  logic        AXI_BREADY,
  input  logic [31:0] AXI_ARADDR,
  input  logic        AXI_ARVALID,
  input  logic [2:0]  AXI_ARPROT,
  output logic        AXI_ARREADY,
  output logic [31:0] AXI_RDATA,
  output logic [1:0]  AXI_RRESP,
  output logic        AXI_RVALID,
  input  logic        AXI_RREADY,
  output logic [31:0] ASHI_WADDR,
  output logic [31:0] ASHI_WINDX,
  output logic [31:0] ASHI_WDATA,
  output logic        ASHI_WRITE,
  input  logic [1:0]  ASHI_WRESP,
  input  logic        ASHI_WIDLE,
  output logic [31:0] ASHI_RADDR,
  output logic [31:0] ASHI_RINDX,
  output logic        ASHI_READ,
  input  logic [31:0] ASHI_RDATA,
  input  logic [1:0]  ASHI_RRESP,
  input  logic        ASHI_RIDLE
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_EXEC = 2'd1;
  localparam logic [1:0] W_WAIT = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_EXEC = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] TO_LAST     = 32'(TIMEOUT_CYCLES - 1);

  logic [1:0]  w_state, r_state;
  logic        aw_held, w_held;
  logic        aw_hs, w_hs, ar_hs;
  logic [31:0] waddr_q, wdata_q, raddr_q, rdata_q;
  logic [1:0]  bresp_q, rresp_q;
  logic        bvalid_q, rvalid_q;

  // Protection, strobes and the timeout setting are unused in some builds.
  logic unused_inputs;
  assign unused_inputs = ^{AXI_AWPROT, AXI_ARPROT, AXI_WSTRB, TO_LAST};

  // Readies are gated by resetn so that every output reads 0 while reset is asserted.
  assign AXI_AWREADY = resetn && (w_state == W_IDLE) && !aw_held;
  assign AXI_WREADY  = resetn && (w_state == W_IDLE) && !w_held;
  assign AXI_ARREADY = resetn && (r_state == R_IDLE);

  assign aw_hs = AXI_AWVALID && AXI_AWREADY;
  assign w_hs  = AXI_WVALID  && AXI_WREADY;
  assign ar_hs = AXI_ARVALID && AXI_ARREADY;

  assign AXI_BRESP  = bresp_q;
  assign AXI_BVALID = bvalid_q;
  assign AXI_RDATA  = rdata_q;
  assign AXI_RRESP  = rresp_q;
  assign AXI_RVALID = rvalid_q;

  assign ASHI_WADDR = waddr_q;
  assign ASHI_WINDX = {2'b00, waddr_q[31:2]};
  assign ASHI_WDATA = wdata_q;
  assign ASHI_WRITE = (w_state == W_EXEC);
  assign ASHI_RADDR = raddr_q;
  assign ASHI_RINDX = {2'b00, raddr_q[31:2]};
  assign ASHI_READ  = (r_state == R_EXEC);

`ifdef AXIL_TIMEOUT_EN
  logic [31:0] w_cnt, r_cnt;
`endif

  // Write path
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      bresp_q  <= '0;
      bvalid_q <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
      w_cnt    <= '0;
`endif
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            waddr_q <= AXI_AWADDR & ADDR_MASK;
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wdata_q <= AXI_WDATA;
          end
          // Advance on the edge that completes the pair so the strobe follows immediately.
          if ((aw_held || aw_hs) && (w_held || w_hs)) w_state <= W_EXEC;
        end
        W_EXEC: begin
          w_state <= W_WAIT;
`ifdef AXIL_TIMEOUT_EN
          w_cnt   <= '0;
`endif
        end
        W_WAIT: begin
          if (ASHI_WIDLE) begin
            bresp_q  <= ASHI_WRESP;
            bvalid_q <= 1'b1;
            w_state  <= W_RESP;
          end
`ifdef AXIL_TIMEOUT_EN
          else if (w_cnt == TO_LAST) begin
            bresp_q  <= RESP_SLVERR;
            bvalid_q <= 1'b1;
            w_state  <= W_RESP;
          end else begin
            w_cnt <= w_cnt + 32'd1;
          end
`endif
        end
        W_RESP: begin
          if (AXI_BREADY) begin
            bvalid_q <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read path
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= R_IDLE;
      raddr_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef AXIL_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            raddr_q <= AXI_ARADDR & ADDR_MASK;
            r_state <= R_EXEC;
          end
        end
        R_EXEC: begin
          r_state <= R_WAIT;
`ifdef AXIL_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        R_WAIT: begin
          if (ASHI_RIDLE) begin
            rdata_q  <= ASHI_RDATA;
            rresp_q  <= ASHI_RRESP;
            rvalid_q <= 1'b1;
            r_state  <= R_RESP;
          end
`ifdef AXIL_TIMEOUT_EN
          else if (r_cnt == TO_LAST) begin
            rdata_q  <= 32'hDEAD_BEEF;
            rresp_q  <= RESP_SLVERR;
            rvalid_q <= 1'b1;
            r_state  <= R_RESP;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
`endif
        end
        R_RESP: begin
          if (AXI_RREADY) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_ashi_bridge.sv
module tb_axil_ashi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] AXI_AWADDR;
  logic        AXI_AWVALID;
  logic [2:0]  AXI_AWPROT;
  logic        AXI_AWREADY;
  logic [31:0] AXI_WDATA;
  logic [3:0]  AXI_WSTRB;
  logic        AXI_WVALID;
  logic        AXI_WREADY;
  logic [1:0]  AXI_BRESP;
  logic        AXI_BVALID;
  logic        AXI_BREADY;
  logic [31:0] AXI_ARADDR;
  logic        AXI_ARVALID;
  logic [2:0]  AXI_ARPROT;
  logic        AXI_ARREADY;
  logic [31:0] AXI_RDATA;
  logic [1:0]  AXI_RRESP;
  logic        AXI_RVALID;
  logic        AXI_RREADY;
  logic [31:0] ASHI_WADDR;
  logic [31:0] ASHI_WINDX;
  logic [31:0] ASHI_WDATA;
  logic        ASHI_WRITE;
  logic [1:0]  ASHI_WRESP;
  logic        ASHI_WIDLE;
  logic [31:0] ASHI_RADDR;
  logic [31:0] ASHI_RINDX;
  logic        ASHI_READ;
  logic [31:0] ASHI_RDATA;
  logic [1:0]  ASHI_RRESP;
  logic        ASHI_RIDLE;

  axil_ashi_bridge #(.ADDR_MASK(32'h7F), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWPROT(AXI_AWPROT),
    .AXI_AWREADY(AXI_AWREADY),
    .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID),
    .AXI_WREADY(AXI_WREADY),
    .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARPROT(AXI_ARPROT),
    .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID),
    .AXI_RREADY(AXI_RREADY),
    .ASHI_WADDR(ASHI_WADDR), .ASHI_WINDX(ASHI_WINDX), .ASHI_WDATA(ASHI_WDATA),
    .ASHI_WRITE(ASHI_WRITE), .ASHI_WRESP(ASHI_WRESP), .ASHI_WIDLE(ASHI_WIDLE),
    .ASHI_RADDR(ASHI_RADDR), .ASHI_RINDX(ASHI_RINDX), .ASHI_READ(ASHI_READ),
    .ASHI_RDATA(ASHI_RDATA), .ASHI_RRESP(ASHI_RRESP), .ASHI_RIDLE(ASHI_RIDLE)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    int          wait_cyc;
    int          stall;
    logic [1:0]  resp;
    logic [31:0] exp_addr;
    logic [31:0] exp_indx;
  } vec_t;

  vec_t vecs [6];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic run_write(input vec_t v);
    AXI_AWADDR  = v.addr;
    AXI_WDATA   = v.data;
    AXI_AWVALID = 1'b1;
    AXI_WVALID  = 1'b1;
    ASHI_WIDLE  = 1'b0;
    ASHI_WRESP  = v.resp;
    samp();
    chk("wr_awready", 32'(AXI_AWREADY), 32'd1);
    chk("wr_wready", 32'(AXI_WREADY), 32'd1);
    tick();
    AXI_AWVALID = 1'b0;
    AXI_WVALID  = 1'b0;
    samp();
    chk("wr_strobe", 32'(ASHI_WRITE), 32'd1);
    chk("wr_waddr", ASHI_WADDR, v.exp_addr);
    chk("wr_windx", ASHI_WINDX, v.exp_indx);
    chk("wr_wdata", ASHI_WDATA, v.data);
    chk("wr_awready_drop", 32'(AXI_AWREADY), 32'd0);
    tick();
    for (int k = 0; k < v.wait_cyc; k++) begin
      samp();
      chk("wr_wait_bvalid", 32'(AXI_BVALID), 32'd0);
      chk("wr_strobe_once", 32'(ASHI_WRITE), 32'd0);
      tick();
    end
    ASHI_WIDLE = 1'b1;
    samp();
    chk("wr_bvalid_early", 32'(AXI_BVALID), 32'd0);
    tick();
    ASHI_WIDLE = 1'b0;
    ASHI_WRESP = ~v.resp;
    samp();
    chk("wr_bvalid", 32'(AXI_BVALID), 32'd1);
    chk("wr_bresp", 32'(AXI_BRESP), 32'(v.resp));
    chk("wr_wready_busy", 32'(AXI_WREADY), 32'd0);
    tick();
    AXI_BREADY = 1'b1;
    samp();
    chk("wr_bvalid_hold", 32'(AXI_BVALID), 32'd1);
    tick();
    AXI_BREADY = 1'b0;
    samp();
    chk("wr_bvalid_clr", 32'(AXI_BVALID), 32'd0);
    chk("wr_awready_back", 32'(AXI_AWREADY), 32'd1);
    chk("wr_wready_back", 32'(AXI_WREADY), 32'd1);
  endtask

  task automatic run_read(input vec_t v);
    AXI_ARADDR  = v.addr;
    AXI_ARVALID = 1'b1;
    ASHI_RIDLE  = 1'b0;
    samp();
    chk("rd_arready", 32'(AXI_ARREADY), 32'd1);
    tick();
    AXI_ARVALID = 1'b0;
    samp();
    chk("rd_strobe", 32'(ASHI_READ), 32'd1);
    chk("rd_raddr", ASHI_RADDR, v.exp_addr);
    chk("rd_rindx", ASHI_RINDX, v.exp_indx);
    chk("rd_arready_drop", 32'(AXI_ARREADY), 32'd0);
    tick();
    for (int k = 0; k < v.wait_cyc; k++) begin
      samp();
      chk("rd_wait_rvalid", 32'(AXI_RVALID), 32'd0);
      chk("rd_strobe_once", 32'(ASHI_READ), 32'd0);
      tick();
    end
    ASHI_RIDLE = 1'b1;
    ASHI_RDATA = v.data;
    ASHI_RRESP = v.resp;
    samp();
    chk("rd_rvalid_early", 32'(AXI_RVALID), 32'd0);
    tick();
    ASHI_RIDLE = 1'b0;
    ASHI_RDATA = ~v.data;
    ASHI_RRESP = ~v.resp;
    samp();
    chk("rd_rvalid", 32'(AXI_RVALID), 32'd1);
    chk("rd_rdata", AXI_RDATA, v.data);
    chk("rd_rresp", 32'(AXI_RRESP), 32'(v.resp));
    for (int k = 0; k < v.stall; k++) begin
      tick();
      samp();
      chk("rd_stall_rvalid", 32'(AXI_RVALID), 32'd1);
      chk("rd_stall_rdata", AXI_RDATA, v.data);
      chk("rd_stall_arready", 32'(AXI_ARREADY), 32'd0);
    end
    tick();
    AXI_RREADY = 1'b1;
    tick();
    AXI_RREADY = 1'b0;
    samp();
    chk("rd_rvalid_clr", 32'(AXI_RVALID), 32'd0);
    chk("rd_arready_back", 32'(AXI_ARREADY), 32'd1);
  endtask

  initial begin
    int n_extra;
    int n_bv;

    //         rd  addr            data            wait stall resp   exp_addr  exp_indx
    vecs[0] = '{1'b0, 32'h0000_0004, 32'h0000_1234, 0, 0, 2'b00, 32'h04, 32'h01};
    vecs[1] = '{1'b0, 32'h0000_007C, 32'hA5A5_5A5A, 2, 0, 2'b10, 32'h7C, 32'h1F};
    vecs[2] = '{1'b0, 32'hFFFF_FF80, 32'h0000_0001, 1, 0, 2'b01, 32'h00, 32'h00};
    vecs[3] = '{1'b1, 32'h0000_0008, 32'h0000_CAFE, 5, 4, 2'b00, 32'h08, 32'h02};
    vecs[4] = '{1'b1, 32'h0001_0013, 32'hDEAD_0001, 0, 0, 2'b11, 32'h13, 32'h04};
    vecs[5] = '{1'b1, 32'h0000_007F, 32'h8000_0000, 1, 1, 2'b10, 32'h7F, 32'h1F};

    resetn = 1'b0;
    AXI_AWADDR = '0; AXI_AWVALID = 1'b0; AXI_AWPROT = 3'b000;
    AXI_WDATA = '0; AXI_WSTRB = 4'hF; AXI_WVALID = 1'b0; AXI_BREADY = 1'b0;
    AXI_ARADDR = '0; AXI_ARVALID = 1'b0; AXI_ARPROT = 3'b000; AXI_RREADY = 1'b0;
    ASHI_WRESP = '0; ASHI_WIDLE = 1'b0; ASHI_RDATA = '0; ASHI_RRESP = '0; ASHI_RIDLE = 1'b0;

    // Reset state
    repeat (2) tick();
    samp();
    chk("rst_awready", 32'(AXI_AWREADY), 32'd0);
    chk("rst_wready", 32'(AXI_WREADY), 32'd0);
    chk("rst_arready", 32'(AXI_ARREADY), 32'd0);
    chk("rst_valids", {30'd0, AXI_BVALID, AXI_RVALID}, 32'd0);
    chk("rst_strobes", {30'd0, ASHI_WRITE, ASHI_READ}, 32'd0);
    chk("rst_waddr", ASHI_WADDR, 32'd0);
    chk("rst_rdata", AXI_RDATA, 32'd0);
    tick();
    resetn = 1'b1;
    samp();
    chk("post_rst_awready", 32'(AXI_AWREADY), 32'd1);
    chk("post_rst_arready", 32'(AXI_ARREADY), 32'd1);
    tick();

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_rd) run_read(vecs[i]);
      else run_write(vecs[i]);
      tick();
    end

    // W arrives three cycles ahead of AW; address above the mask
    AXI_WDATA = 32'h0000_5555;
    AXI_WVALID = 1'b1;
    ASHI_WIDLE = 1'b0;
    samp();
    chk("t2_wready", 32'(AXI_WREADY), 32'd1);
    tick();
    AXI_WVALID = 1'b0;
    samp();
    chk("t2_wready_drop", 32'(AXI_WREADY), 32'd0);
    chk("t2_no_strobe", 32'(ASHI_WRITE), 32'd0);
    tick();
    samp();
    chk("t2_wready_low", 32'(AXI_WREADY), 32'd0);
    chk("t2_awready_hi", 32'(AXI_AWREADY), 32'd1);
    tick();
    AXI_AWADDR = 32'h0000_0084;
    AXI_AWVALID = 1'b1;
    samp();
    chk("t2_awready", 32'(AXI_AWREADY), 32'd1);
    tick();
    AXI_AWVALID = 1'b0;
    samp();
    chk("t2_strobe", 32'(ASHI_WRITE), 32'd1);
    chk("t2_waddr", ASHI_WADDR, 32'h04);
    chk("t2_wdata", ASHI_WDATA, 32'h5555);
    n_extra = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      samp();
      if (ASHI_WRITE) n_extra++;
      chk("t2_wready_wait", 32'(AXI_WREADY), 32'd0);
    end
    tick();
    ASHI_WIDLE = 1'b1;
    ASHI_WRESP = 2'b00;
    tick();
    ASHI_WIDLE = 1'b0;
    samp();
    chk("t2_single_strobe", 32'(n_extra), 32'd0);
    chk("t2_bvalid", 32'(AXI_BVALID), 32'd1);
    chk("t2_wready_resp", 32'(AXI_WREADY), 32'd0);
    tick();
    AXI_BREADY = 1'b1;
    tick();
    AXI_BREADY = 1'b0;
    samp();
    chk("t2_bvalid_clr", 32'(AXI_BVALID), 32'd0);
    chk("t2_wready_back", 32'(AXI_WREADY), 32'd1);
    tick();

    // Simultaneous read and write
    AXI_AWADDR = 32'h0000_0010; AXI_WDATA = 32'h0BAD_F00D;
    AXI_ARADDR = 32'h0000_0020;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1; AXI_ARVALID = 1'b1;
    ASHI_WIDLE = 1'b0; ASHI_RIDLE = 1'b0;
    tick();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0; AXI_ARVALID = 1'b0;
    samp();
    chk("t4_both_strobes", {30'd0, ASHI_WRITE, ASHI_READ}, 32'd3);
    chk("t4_windx", ASHI_WINDX, 32'd4);
    chk("t4_rindx", ASHI_RINDX, 32'd8);
    tick();
    ASHI_WIDLE = 1'b1; ASHI_WRESP = 2'b01;
    tick();
    ASHI_WIDLE = 1'b0;
    samp();
    chk("t4_bvalid", 32'(AXI_BVALID), 32'd1);
    chk("t4_bresp", 32'(AXI_BRESP), 32'd1);
    chk("t4_rvalid_pending", 32'(AXI_RVALID), 32'd0);
    tick();
    AXI_BREADY = 1'b1;
    ASHI_RIDLE = 1'b1; ASHI_RDATA = 32'h1357_9BDF; ASHI_RRESP = 2'b00;
    tick();
    AXI_BREADY = 1'b0;
    ASHI_RIDLE = 1'b0;
    samp();
    chk("t4_bvalid_clr", 32'(AXI_BVALID), 32'd0);
    chk("t4_rvalid", 32'(AXI_RVALID), 32'd1);
    chk("t4_rdata", AXI_RDATA, 32'h1357_9BDF);
    tick();
    AXI_RREADY = 1'b1;
    tick();
    AXI_RREADY = 1'b0;
    samp();
    chk("t4_rvalid_clr", 32'(AXI_RVALID), 32'd0);
    tick();

    // Reset pulse while the write path waits on the handler
    AXI_AWADDR = 32'h0000_0018; AXI_WDATA = 32'h0000_0077;
    AXI_AWVALID = 1'b1; AXI_WVALID = 1'b1;
    ASHI_WIDLE = 1'b0;
    tick();
    AXI_AWVALID = 1'b0; AXI_WVALID = 1'b0;
    tick();
    samp();
    chk("t5_in_wait_awready", 32'(AXI_AWREADY), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_rst_readies", {29'd0, AXI_AWREADY, AXI_WREADY, AXI_ARREADY}, 32'd0);
    chk("t5_rst_waddr", ASHI_WADDR, 32'd0);
    chk("t5_rst_windx", ASHI_WINDX, 32'd0);
    chk("t5_rst_wdata", ASHI_WDATA, 32'd0);
    chk("t5_rst_misc", {30'd0, AXI_BVALID, ASHI_WRITE}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    ASHI_WIDLE = 1'b1;
    n_bv = 0;
    for (int k = 0; k < 4; k++) begin
      samp();
      if (AXI_BVALID) n_bv++;
      tick();
    end
    chk("t5_no_bvalid", 32'(n_bv), 32'd0);
    ASHI_WIDLE = 1'b0;
    run_write(vecs[0]);
    tick();

`ifdef AXIL_TIMEOUT_EN
    // Handler never reports read idle
    begin
      int n_wait;
      n_wait = 0;
      AXI_ARADDR = 32'h0000_000C;
      AXI_ARVALID = 1'b1;
      ASHI_RIDLE = 1'b0;
      tick();
      AXI_ARVALID = 1'b0;
      samp();
      chk("t6_strobe", 32'(ASHI_READ), 32'd1);
      for (int k = 0; k < 100; k++) begin
        tick();
        samp();
        if (AXI_RVALID) break;
        n_wait++;
      end
      chk("t6_wait_cycles", 32'(n_wait), 32'd16);
      chk("t6_rvalid", 32'(AXI_RVALID), 32'd1);
      chk("t6_rresp", 32'(AXI_RRESP), 32'd2);
      chk("t6_rdata", AXI_RDATA, 32'hDEAD_BEEF);
      tick();
      AXI_RREADY = 1'b1;
      tick();
      AXI_RREADY = 1'b0;
      samp();
      chk("t6_rvalid_clr", 32'(AXI_RVALID), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
